// File: rtl/fpcdiv_pkg.sv
// Shared definitions for the iterative fixed-point complex divider.
//   state_t    : controller states (IDLE, MUL, DIV, DONE)
//   iter_count : number of restoring-division iterations (n + d)
//   cnt_width  : width of the iteration counter, wide enough to hold n + d
package fpcdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int iter_count(input int n, input int d);
    return n + d;
  endfunction

  function automatic int cnt_width(input int n, input int d);
    return $clog2(n + d + 1);
  endfunction

endpackage

// File: rtl/fpdiv_restoring_step.sv
// Unsigned iterative restoring divider, one quotient bit per clock.
//   clk      : clock
//   load     : capture dividend, clear partial remainder
//   step     : perform one restoring iteration
//   divisor  : n-bit unsigned divisor, held stable by the caller while stepping
//   dividend : (n+d)-bit unsigned dividend, sampled on load
//   quotient : low n bits of the quotient (valid after n+d steps)
// The dividend register doubles as the quotient register: each step shifts
// out one dividend bit at the top and shifts in one quotient bit at the bottom.
module fpdiv_restoring_step #(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [n-1:0]     divisor,
  input  logic [n+d-1:0]   dividend,
  output logic [n-1:0]     quotient
);

  localparam int W = n + d;

  logic [n-1:0] rem_p0;
  logic [W-1:0] quo_p0;
  logic [n:0]   trial;
  logic [n-1:0] diff;
  logic         take;

  // Remainder stays below the divisor, so the shifted trial value needs one
  // extra bit and the restored difference always fits back into n bits.
  always_comb begin
    trial = {rem_p0, quo_p0[W-1]};
    take  = (trial >= {1'b0, divisor});
    diff  = trial[n-1:0] - divisor;
  end

  // ---- iteration register ----
  always_ff @(posedge clk) begin
    if (load) begin
      rem_p0 <= '0;
      quo_p0 <= dividend;
    end else if (step) begin
      rem_p0 <= take ? diff : trial[n-1:0];
      quo_p0 <= {quo_p0[W-2:0], take};
    end
  end

  assign quotient = quo_p0[n-1:0];

endmodule

// File: rtl/fpcdiv_iter.sv
// Fixed-point iterative complex divider: c = a / b on signed Q(n-d).d operands,
// evaluated as a*conj(b) / |b|^2 with one multiply cycle followed by n+d
// restoring-division cycles on two dividers sharing the |b|^2 divisor.
//   clk, reset          : clock, asynchronous active-low reset
//   recv_val / recv_rdy : operand handshake (ready only in IDLE)
//   ar, ac / br, bc     : dividend / divisor real and imaginary parts
//   send_val / send_rdy : result handshake (valid only in DONE)
//   cr, cc              : quotient real and imaginary parts, toward-zero
//   div_by_zero         : result flag when |b|^2 evaluates to zero
module fpcdiv_iter
  import fpcdiv_pkg::*;
#(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] cr,
  output logic [n-1:0] cc,
  output logic         div_by_zero
);

  localparam int ITER = iter_count(n, d);
  localparam int CW   = cnt_width(n, d);

  state_t state, state_nx;

  logic [CW-1:0]        cnt;
  logic                 dbz;
  logic                 accept, load, step, last, den_zero;

  logic signed [n-1:0]  ar_p0, ac_p0, br_p0, bc_p0;
  logic signed [n-1:0]  num_r, num_c, den;
  logic [n+d-1:0]       dvd_r, dvd_c;

  logic [n-1:0]         den_mag_p1;
  logic                 neg_r_p1, neg_c_p1;
  logic [n-1:0]         quo_r, quo_c;

  // Fixed-point product: full 2n-bit product, floor-shifted by d, wrapped to n.
  function automatic logic signed [n-1:0] fx_mul(input logic signed [n-1:0] x,
                                                  input logic signed [n-1:0] y);
    logic signed [2*n-1:0] p;
    p = x * y;
    return n'(p >>> d);
  endfunction

  // Magnitude as unsigned; the most negative value maps to 2^(n-1) correctly.
  function automatic logic [n-1:0] mag(input logic signed [n-1:0] x);
    return x[n-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  function automatic logic [n-1:0] apply_sign(input logic [n-1:0] q, input logic neg);
    return neg ? -q : q;
  endfunction

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (recv_val) state_nx = MUL;
      MUL:     state_nx = den_zero ? DONE : DIV;
      DIV:     if (last) state_nx = DONE;
      DONE:    if (send_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    recv_rdy = (state == IDLE);
    send_val = (state == DONE);
    accept   = (state == IDLE) && recv_val;
    load     = (state == MUL) && !den_zero;
    step     = (state == DIV);
  end

  assign last = (cnt == CW'(ITER - 1));

  // ---- control registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      dbz <= 1'b0;
    end else begin
      if (state == MUL)  cnt <= '0;
      else if (step)     cnt <= cnt + 1'b1;
      if (accept)                          dbz <= 1'b0;
      else if ((state == MUL) && den_zero) dbz <= 1'b1;
    end
  end

  // ---- stage p0: operand capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      ar_p0 <= ar;
      ac_p0 <= ac;
      br_p0 <= br;
      bc_p0 <= bc;
    end
  end

  always_comb begin
    num_r    = fx_mul(ar_p0, br_p0) + fx_mul(ac_p0, bc_p0);
    num_c    = fx_mul(ac_p0, br_p0) - fx_mul(ar_p0, bc_p0);
    den      = fx_mul(br_p0, br_p0) + fx_mul(bc_p0, bc_p0);
    den_zero = (den == '0);
    dvd_r    = {mag(num_r), {d{1'b0}}};
    dvd_c    = {mag(num_c), {d{1'b0}}};
  end

  // ---- stage p1: divisor and result signs, fixed for the whole division ----
  always_ff @(posedge clk) begin
    if (load) begin
      den_mag_p1 <= mag(den);
      neg_r_p1   <= num_r[n-1] ^ den[n-1];
      neg_c_p1   <= num_c[n-1] ^ den[n-1];
    end
  end

  fpdiv_restoring_step #(.n(n), .d(d)) u_div_r (
    .clk      (clk),
    .load     (load),
    .step     (step),
    .divisor  (den_mag_p1),
    .dividend (dvd_r),
    .quotient (quo_r)
  );

  fpdiv_restoring_step #(.n(n), .d(d)) u_div_c (
    .clk      (clk),
    .load     (load),
    .step     (step),
    .divisor  (den_mag_p1),
    .dividend (dvd_c),
    .quotient (quo_c)
  );

  // Results are presented only in DONE; a zero divisor forces them to zero.
  always_comb begin
    cr = '0;
    cc = '0;
    if (send_val && !dbz) begin
      cr = apply_sign(quo_r, neg_r_p1);
      cc = apply_sign(quo_c, neg_c_p1);
    end
  end

  assign div_by_zero = dbz;

endmodule
